// File: rtl/pc_pkg.sv
// Shared constants for the program-counter block: default geometry and the
// encoding of the single action resolved from the control inputs each cycle.
package pc_pkg;

  localparam int PC_WIDTH = 16;
  localparam int PC_DEPTH = 8;

  typedef logic [2:0] act_t;

  localparam act_t ACT_CLR  = 3'd0;
  localparam act_t ACT_HOLD = 3'd1;
  localparam act_t ACT_CALL = 3'd2;
  localparam act_t ACT_RET  = 3'd3;
  localparam act_t ACT_LOAD = 3'd4;
  localparam act_t ACT_INCR = 3'd5;
  localparam act_t ACT_IDLE = 3'd6;

endpackage

// File: rtl/ret_stack.sv
// Register-array LIFO holding return addresses. Pushes while full and pops
// while empty are dropped; only the occupancy count is reset.
module ret_stack #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] top_o,
  output logic [SPW-1:0]   sp_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [IW-1:0]    wr_idx, top_idx;
  logic             do_push, do_pop;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_idx  = IW'(sp_q);
  assign top_idx = IW'(sp_q - SPW'(1));
  assign top_o   = mem_q[top_idx];
  assign sp_o    = sp_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sp_d = sp_q;
    if (clr_i)        sp_d = '0;
    else if (do_push) sp_d = sp_q + SPW'(1);
    else if (do_pop)  sp_d = sp_q - SPW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // NOTE: the data array has no reset; entries above sp are never read as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with an integrated return-address stack, hold input and
// sticky overflow/underflow flags. One prioritised action per clock edge.
module pc_stack
  import pc_pkg::*;
#(
  parameter  int WIDTH = PC_WIDTH,
  parameter  int DEPTH = PC_DEPTH,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             clr,
  input  logic             hold,
  input  logic             call,
  input  logic             ret,
  input  logic             load,
  input  logic             incr,
  output logic [WIDTH-1:0] out,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  act_t             act;
  logic [WIDTH-1:0] out_q, out_d, ret_addr, top;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, stk_clr;

  always_comb begin
    act = ACT_IDLE;
    if (clr)       act = ACT_CLR;
    else if (hold) act = ACT_HOLD;
    else if (call) act = ACT_CALL;
    else if (ret)  act = ACT_RET;
    else if (load) act = ACT_LOAD;
    else if (incr) act = ACT_INCR;
  end

  assign ret_addr = out_q + WIDTH'(1);

  always_comb begin
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    stk_clr = 1'b0;
    case (act)
      ACT_CLR: begin
        out_d   = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        stk_clr = 1'b1;
      end
      // Overflowing call still jumps; only the return address is lost.
      ACT_CALL: begin
        out_d = in;
        if (full) ovf_d = 1'b1;
        else      push  = 1'b1;
      end
      ACT_RET: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          out_d = top;
          pop   = 1'b1;
        end
      end
      ACT_LOAD: out_d = in;
      ACT_INCR: out_d = ret_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (stk_clr),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(ret_addr),
    .top_o  (top),
    .sp_o   (sp),
    .full_o (full),
    .empty_o(empty)
  );

  assign out = out_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Randomised scoreboard bench for pc_stack: two instances (16-bit/8-deep and
// 4-bit/4-deep) share the controls and are checked against a stack model.
module tb_pc_stack;
  import pc_pkg::*;

  typedef struct {
    int unsigned out;
    int unsigned sp;
    bit          ovf;
    bit          unf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_s;
  logic        clr_s, hold_s, call_s, ret_s, load_s, incr_s;

  logic [15:0] out16;
  logic [3:0]  sp16;
  logic        empty16, full16, ovf16, unf16;
  logic [3:0]  out4;
  logic [2:0]  sp4;
  logic        empty4, full4, ovf4, unf4;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp0_q[$];
  exp_t exp1_q[$];

  // Reference model state: instance 0 is 16-bit/8-deep, instance 1 is 4-bit/4-deep.
  int unsigned m_out  [2];
  int unsigned m_sp   [2];
  bit          m_ovf  [2];
  bit          m_unf  [2];
  int unsigned m_stk  [2][8];
  int unsigned m_mask [2] = '{32'hFFFF, 32'hF};
  int unsigned m_depth[2] = '{8, 4};

  always #5 clk = ~clk;

  pc_stack #(.WIDTH(16), .DEPTH(8)) u_dut16 (
    .clk(clk), .reset(reset), .in(in_s), .clr(clr_s), .hold(hold_s),
    .call(call_s), .ret(ret_s), .load(load_s), .incr(incr_s),
    .out(out16), .sp(sp16), .empty(empty16), .full(full16), .ovf(ovf16), .unf(unf16)
  );

  pc_stack #(.WIDTH(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .in(in_s[3:0]), .clr(clr_s), .hold(hold_s),
    .call(call_s), .ret(ret_s), .load(load_s), .incr(incr_s),
    .out(out4), .sp(sp4), .empty(empty4), .full(full4), .ovf(ovf4), .unf(unf4)
  );

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input int k, input exp_t e);
    logic [31:0] o, s, em, fu, ov, un;
    if (k == 0) begin
      o = 32'(out16); s = 32'(sp16); em = 32'(empty16); fu = 32'(full16); ov = 32'(ovf16); un = 32'(unf16);
    end else begin
      o = 32'(out4); s = 32'(sp4); em = 32'(empty4); fu = 32'(full4); ov = 32'(ovf4); un = 32'(unf4);
    end
    check($sformatf("%s[%0d].out", tag, k), o, e.out);
    check($sformatf("%s[%0d].sp", tag, k), s, e.sp);
    check($sformatf("%s[%0d].empty", tag, k), em, 32'(e.sp == 0));
    check($sformatf("%s[%0d].full", tag, k), fu, 32'(e.sp == m_depth[k]));
    check($sformatf("%s[%0d].ovf", tag, k), ov, 32'(e.ovf));
    check($sformatf("%s[%0d].unf", tag, k), un, 32'(e.unf));
  endtask

  function automatic exp_t snap(int k);
    exp_t e;
    e.out = m_out[k];
    e.sp  = m_sp[k];
    e.ovf = m_ovf[k];
    e.unf = m_unf[k];
    return e;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 0; m_sp[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, bit c_clr, bit c_hold, bit c_call,
                                     bit c_ret, bit c_load, bit c_incr, int unsigned din);
    act_t a;
    a = ACT_IDLE;
    if (c_clr)       a = ACT_CLR;
    else if (c_hold) a = ACT_HOLD;
    else if (c_call) a = ACT_CALL;
    else if (c_ret)  a = ACT_RET;
    else if (c_load) a = ACT_LOAD;
    else if (c_incr) a = ACT_INCR;
    case (a)
      ACT_CLR: begin m_out[k] = 0; m_sp[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; end
      ACT_CALL: begin
        if (m_sp[k] < m_depth[k]) begin
          m_stk[k][m_sp[k]] = (m_out[k] + 1) & m_mask[k];
          m_sp[k]++;
        end else m_ovf[k] = 1;
        m_out[k] = din & m_mask[k];
      end
      ACT_RET: begin
        if (m_sp[k] > 0) begin
          m_sp[k]--;
          m_out[k] = m_stk[k][m_sp[k]];
        end else m_unf[k] = 1;
      end
      ACT_LOAD: m_out[k] = din & m_mask[k];
      ACT_INCR: m_out[k] = (m_out[k] + 1) & m_mask[k];
      default: ;
    endcase
  endfunction

  // Drive one cycle of controls and queue the state expected after the edge.
  task automatic step(input bit c_clr, input bit c_hold, input bit c_call, input bit c_ret,
                      input bit c_load, input bit c_incr, input logic [15:0] din);
    @(negedge clk);
    clr_s = c_clr; hold_s = c_hold; call_s = c_call; ret_s = c_ret;
    load_s = c_load; incr_s = c_incr; in_s = din;
    for (int k = 0; k < 2; k++)
      model_step(k, c_clr, c_hold, c_call, c_ret, c_load, c_incr, 32'(din));
    exp0_q.push_back(snap(0));
    exp1_q.push_back(snap(1));
  endtask

  task automatic idle_inputs();
    clr_s = 0; hold_s = 0; call_s = 0; ret_s = 0; load_s = 0; incr_s = 0; in_s = '0;
  endtask

  // Reset asserted mid-cycle must clear state without waiting for an edge.
  task automatic async_reset();
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b0;
    #1 model_reset();
    cmp_all("async_reset", 0, snap(0));
    cmp_all("async_reset", 1, snap(1));
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every edge yields a new state; compare it with the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp0_q.size() > 0) cmp_all("cycle", 0, exp0_q.pop_front());
      if (exp1_q.size() > 0) cmp_all("cycle", 1, exp1_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    cmp_all("reset", 0, snap(0));
    cmp_all("reset", 1, snap(1));
    @(negedge clk);
    reset = 1'b1;

    repeat (3) step(0, 0, 0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 0, 1, 0, 16'h0005);
    step(0, 0, 1, 0, 0, 0, 16'h0100);
    step(0, 0, 0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0, 16'(16'h0010 * (i + 1)));
    step(0, 0, 1, 0, 0, 0, 16'h0200);
    repeat (8) step(0, 0, 0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 1, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 1, 0, 16'h0033);
    step(0, 0, 1, 0, 0, 0, 16'h0021);
    repeat (3) step(0, 1, 1, 0, 1, 1, 16'h0ABC);
    step(0, 0, 0, 0, 1, 1, 16'h0044);
    step(0, 0, 0, 0, 1, 0, 16'h000F);
    step(0, 0, 0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 0, 1, 0, 16'hFFFF);
    step(0, 0, 0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 0, 1, 0, 16'h000F);
    step(0, 0, 1, 0, 0, 0, 16'h0007);
    step(0, 0, 0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 1, 0, 16'hFFFF);
    step(0, 0, 1, 0, 0, 0, 16'h0009);
    step(0, 0, 0, 1, 0, 0, 16'h0);
    repeat (3) step(0, 0, 1, 0, 0, 0, 16'h0123);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, 16'($urandom));
    end

    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, expected 0", exp0_q.size(), exp1_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
